// File: rtl/miss_ctrl.sv
// miss_ctrl: L1 miss sequencer behind the tag/valid/LRU compare stage.
// Hits update PLRU/modified bits in the access cycle. Misses run an optional
// victim write-back, then a line fill, then a one-cycle tag install. The PE is
// stalled while the miss is handled, and saturating event counters are kept.
module miss_ctrl #(
  parameter int TAG_W = 14,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pe_access_d,
  input  logic                   pe_write_d,
  input  logic [TAG_W-1:0]       pe_tag_d,
  input  logic [IDX_W-1:0]       pe_index_d,
  input  logic [3:0]             way_hit_d,
  input  logic                   way_is_selected_d,
  input  logic                   req_clean_d,
  input  logic [3:0]             fill_or_victim_way_d,
  input  logic [TAG_W-1:0]       victim_tag_d,
  input  logic [2:0]             lru_output_d,
  output logic                   pe_stall,
  output logic                   lru_we,
  output logic [2:0]             lru_wdata,
  output logic [3:0]             mod_we,
  output logic                   mod_wdata,
  output logic [3:0]             tag_we,
  output logic [TAG_W-1:0]       tag_wdata,
  output logic [IDX_W-1:0]       wr_index,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  input  logic                   mem_ack,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       wb_cnt
);

  typedef enum logic [1:0] {IDLE, WB, FILL, UPDATE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       vic_q;
  logic [TAG_W-1:0] vtag_q;
  logic [TAG_W-1:0] ptag_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       lru_q;
  logic             hit_ev, miss_ev, wb_ev;

  // Tree PLRU touch: bit2 picks the half, bit1/bit0 the way inside each half.
  function automatic logic [2:0] plru_touch(input logic [3:0] way, input logic [2:0] bits);
    logic [2:0] r;
    r = bits;
    if (way[3]) begin
      r[2] = 1'b1;
      r[1] = 1'b1;
    end else if (way[2]) begin
      r[2] = 1'b1;
      r[1] = 1'b0;
    end else if (way[1]) begin
      r[2] = 1'b0;
      r[0] = 1'b1;
    end else if (way[0]) begin
      r[2] = 1'b0;
      r[0] = 1'b0;
    end
    return r;
  endfunction

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next state and all strobes; everything is held at zero while in reset so
  // an abandoned miss cannot write the arrays or keep the memory request up.
  always_comb begin
    state_nxt = state;
    pe_stall  = 1'b0;
    lru_we    = 1'b0;
    lru_wdata = 3'b000;
    mod_we    = 4'b0000;
    mod_wdata = 1'b0;
    tag_we    = 4'b0000;
    tag_wdata = '0;
    wr_index  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    wb_ev     = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          pe_stall = pe_access_d & ~way_is_selected_d;
          if (pe_access_d && way_is_selected_d) begin
            hit_ev    = 1'b1;
            lru_we    = 1'b1;
            wr_index  = pe_index_d;
            lru_wdata = plru_touch(way_hit_d, lru_output_d);
            if (pe_write_d) begin
              mod_we    = way_hit_d;
              mod_wdata = 1'b1;
            end
          end else if (pe_access_d) begin
            miss_ev   = 1'b1;
            state_nxt = req_clean_d ? FILL : WB;
          end
        end
        WB: begin
          pe_stall = 1'b1;
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {vtag_q, idx_q};
          wr_index = idx_q;
          if (mem_ack) begin
            wb_ev     = 1'b1;
            mod_we    = vic_q;
            state_nxt = FILL;
          end
        end
        FILL: begin
          pe_stall = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {ptag_q, idx_q};
          wr_index = idx_q;
          if (mem_ack) state_nxt = UPDATE;
        end
        UPDATE: begin
          pe_stall  = 1'b1;
          tag_we    = vic_q;
          tag_wdata = ptag_q;
          mod_we    = vic_q;
          lru_we    = 1'b1;
          lru_wdata = plru_touch(vic_q, lru_q);
          wr_index  = idx_q;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Freeze the missing request and its victim so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (miss_ev) begin
      vic_q  <= fill_or_victim_way_d;
      vtag_q <= victim_tag_d;
      ptag_q <= pe_tag_d;
      idx_q  <= pe_index_d;
      lru_q  <= lru_output_d;
    end
  end

  // Saturating hit/miss/write-back counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_ev)  hit_cnt  <= sat_inc(hit_cnt);
      if (miss_ev) miss_cnt <= sat_inc(miss_cnt);
      if (wb_ev)   wb_cnt   <= sat_inc(wb_cnt);
    end
  end

`ifndef SYNTHESIS
  // The victim way handed over on a miss must name exactly one way.
  always_ff @(posedge clk) begin
    if (miss_ev) assert ($onehot(fill_or_victim_way_d));
  end
`endif

endmodule

// File: tb/tb_miss_ctrl.sv
// tb_miss_ctrl: drives miss_ctrl from a small cache model that plays the
// compare stage and the memory, and checks every cycle against that model.
module tb_miss_ctrl;
  localparam int TAG_W = 14;
  localparam int IDX_W = 8;
  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   pe_access_d, pe_write_d;
  logic [TAG_W-1:0]       pe_tag_d;
  logic [IDX_W-1:0]       pe_index_d;
  logic [3:0]             way_hit_d;
  logic                   way_is_selected_d;
  logic                   req_clean_d;
  logic [3:0]             fill_or_victim_way_d;
  logic [TAG_W-1:0]       victim_tag_d;
  logic [2:0]             lru_output_d;
  logic                   pe_stall, lru_we, mod_wdata, mem_req, mem_we, mem_ack;
  logic [2:0]             lru_wdata;
  logic [3:0]             mod_we, tag_we;
  logic [TAG_W-1:0]       tag_wdata;
  logic [IDX_W-1:0]       wr_index;
  logic [TAG_W+IDX_W-1:0] mem_addr;
  logic [CNT_W-1:0]       hit_cnt, miss_cnt, wb_cnt;

  miss_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .pe_access_d(pe_access_d), .pe_write_d(pe_write_d),
    .pe_tag_d(pe_tag_d), .pe_index_d(pe_index_d),
    .way_hit_d(way_hit_d), .way_is_selected_d(way_is_selected_d),
    .req_clean_d(req_clean_d), .fill_or_victim_way_d(fill_or_victim_way_d),
    .victim_tag_d(victim_tag_d), .lru_output_d(lru_output_d),
    .pe_stall(pe_stall), .lru_we(lru_we), .lru_wdata(lru_wdata),
    .mod_we(mod_we), .mod_wdata(mod_wdata), .tag_we(tag_we),
    .tag_wdata(tag_wdata), .wr_index(wr_index),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  // Cache model: what the tag/valid/mod/LRU arrays hold.
  logic [TAG_W-1:0] m_tag   [256][4];
  bit               m_val   [256][4];
  bit               m_dirty [256][4];
  logic [2:0]       m_lru   [256];

  int checks, errors;
  int e_hit, e_miss, e_wb;
  int hitw, vicw;
  logic [2:0]             obs_lru, obs_upd_lru;
  logic [3:0]             obs_mod_we, obs_upd_tag_we;
  logic [TAG_W+IDX_W-1:0] obs_wb_addr, obs_fill_addr;

  logic [IDX_W-1:0] idx_pool [4] = '{8'h05, 8'h10, 8'h33, 8'hFF};
  logic [TAG_W-1:0] tag_pool [6] = '{14'h1A2, 14'h3FF, 14'h001, 14'h2AB, 14'h3C0, 14'h155};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Touching way w: bit2 says which half was used; the bit for that half says which way.
  function automatic logic [2:0] ref_touch(input int w, input logic [2:0] b);
    logic [2:0] r;
    r = b;
    r[2] = (w >= 2);
    if (w >= 2) r[1] = (w == 3);
    else        r[0] = (w == 1);
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic chk_cnt();
    chk("hit_cnt",  32'(hit_cnt),  32'(e_hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(e_miss));
    chk("wb_cnt",   32'(wb_cnt),   32'(e_wb));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(pe_stall), 0);
    chk({tag, "_lru_we"}, 32'(lru_we), 0);
    chk({tag, "_lru_wd"}, 32'(lru_wdata), 0);
    chk({tag, "_mod_we"}, 32'(mod_we), 0);
    chk({tag, "_mod_wd"}, 32'(mod_wdata), 0);
    chk({tag, "_tag_we"}, 32'(tag_we), 0);
    chk({tag, "_tag_wd"}, 32'(tag_wdata), 0);
    chk({tag, "_wr_idx"}, 32'(wr_index), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
  endtask

  // Compare-stage outputs as the arrays would present them for (tag, idx).
  task automatic drive_compare(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx);
    hitw = -1;
    vicw = -1;
    for (int w = 0; w < 4; w++)
      if (m_val[idx][w] && m_tag[idx][w] == tag) hitw = w;
    for (int w = 0; w < 4; w++)
      if (!m_val[idx][w] && vicw < 0) vicw = w;
    if (vicw < 0) begin
      if (m_lru[idx][2]) vicw = m_lru[idx][0] ? 0 : 1;
      else               vicw = m_lru[idx][1] ? 2 : 3;
    end
    way_hit_d            = (hitw >= 0) ? (4'b0001 << hitw) : 4'b0000;
    way_is_selected_d    = (hitw >= 0);
    fill_or_victim_way_d = 4'b0001 << vicw;
    victim_tag_d         = m_tag[idx][vicw];
    req_clean_d          = !(m_val[idx][vicw] && m_dirty[idx][vicw]);
    lru_output_d         = m_lru[idx];
  endtask

  // Compare-stage outputs wander while the miss is in flight; none may matter.
  task automatic scramble();
    way_hit_d            = 4'b0000;
    way_is_selected_d    = 1'b0;
    victim_tag_d         = TAG_W'($urandom);
    lru_output_d         = 3'($urandom);
    req_clean_d          = 1'($urandom);
    fill_or_victim_way_d = 4'b0001 << $urandom_range(0, 3);
  endtask

  task automatic idle_cycle(input bit ack);
    pe_access_d = 1'b0;
    pe_write_d  = 1'($urandom);
    scramble();
    mem_ack = ack;
    @(negedge clk);
    chk_cnt();
    chk_zero("idle");
    @(posedge clk); #1;
  endtask

  // One memory phase (write-back or fill); ack_dly>0 acks in that cycle, else random.
  task automatic mem_phase(input bit is_wb, input logic [TAG_W+IDX_W-1:0] addr,
                           input int ack_dly, input int vic, inout int stall);
    bit ack;
    for (int n = 0; n < 8; n++) begin
      scramble();
      if (ack_dly > 0) ack = (n == ack_dly - 1);
      else             ack = ($urandom_range(0, 2) == 0);
      if (n == 7) ack = 1'b1;
      mem_ack = ack;
      @(negedge clk);
      chk_cnt();
      chk(is_wb ? "wb_req" : "fill_req", 32'(mem_req), 1);
      chk(is_wb ? "wb_we" : "fill_we", 32'(mem_we), 32'(is_wb));
      chk(is_wb ? "wb_addr" : "fill_addr", 32'(mem_addr), 32'(addr));
      chk("mem_stall", 32'(pe_stall), 1);
      chk("mem_tag_we", 32'(tag_we), 0);
      chk("mem_lru_we", 32'(lru_we), 0);
      chk("mem_mod_we", 32'(mod_we), (is_wb && ack) ? 32'(4'b0001 << vic) : 0);
      chk("mem_mod_wd", 32'(mod_wdata), 0);
      if (is_wb) obs_wb_addr = mem_addr;
      else       obs_fill_addr = mem_addr;
      stall++;
      if (is_wb && ack) e_wb = sat(e_wb);
      @(posedge clk); #1;
      if (ack) break;
    end
  endtask

  // A PE access held until it hits; misses are served by the memory model.
  task automatic do_access(input bit wr, input logic [TAG_W-1:0] tag,
                           input logic [IDX_W-1:0] idx, input int ack_dly,
                           output int stall);
    bit done;
    int vic;
    logic [TAG_W-1:0] vtag;
    logic [2:0] lru_cap;
    logic [2:0] exp_lru;
    bit dirty;
    stall = 0;
    done = 0;
    pe_access_d = 1'b1;
    pe_write_d  = wr;
    pe_tag_d    = tag;
    pe_index_d  = idx;
    for (int t = 0; t < 3 && !done; t++) begin
      drive_compare(tag, idx);
      mem_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chk_cnt();
      if (hitw >= 0) begin
        exp_lru = ref_touch(hitw, m_lru[idx]);
        chk("hit_stall", 32'(pe_stall), 0);
        chk("hit_lru_we", 32'(lru_we), 1);
        chk("hit_lru_wd", 32'(lru_wdata), 32'(exp_lru));
        chk("hit_wr_idx", 32'(wr_index), 32'(idx));
        chk("hit_mod_we", 32'(mod_we), wr ? 32'(4'b0001 << hitw) : 0);
        chk("hit_mod_wd", 32'(mod_wdata), 32'(wr));
        chk("hit_tag_we", 32'(tag_we), 0);
        chk("hit_mem_req", 32'(mem_req), 0);
        obs_lru    = lru_wdata;
        obs_mod_we = mod_we;
        m_lru[idx] = exp_lru;
        if (wr) m_dirty[idx][hitw] = 1;
        e_hit = sat(e_hit);
        done = 1;
        @(posedge clk); #1;
      end else begin
        chk("miss_stall", 32'(pe_stall), 1);
        chk("miss_lru_we", 32'(lru_we), 0);
        chk("miss_mod_we", 32'(mod_we), 0);
        chk("miss_mem_req", 32'(mem_req), 0);
        vic     = vicw;
        vtag    = m_tag[idx][vic];
        dirty   = m_val[idx][vic] && m_dirty[idx][vic];
        lru_cap = m_lru[idx];
        e_miss  = sat(e_miss);
        stall++;
        @(posedge clk); #1;
        if (dirty) mem_phase(1'b1, {vtag, idx}, ack_dly, vic, stall);
        mem_phase(1'b0, {tag, idx}, ack_dly, vic, stall);
        scramble();
        mem_ack = 1'($urandom);
        @(negedge clk);
        chk_cnt();
        exp_lru = ref_touch(vic, lru_cap);
        chk("upd_stall", 32'(pe_stall), 1);
        chk("upd_tag_we", 32'(tag_we), 32'(4'b0001 << vic));
        chk("upd_tag_wd", 32'(tag_wdata), 32'(tag));
        chk("upd_mod_we", 32'(mod_we), 32'(4'b0001 << vic));
        chk("upd_mod_wd", 32'(mod_wdata), 0);
        chk("upd_lru_we", 32'(lru_we), 1);
        chk("upd_lru_wd", 32'(lru_wdata), 32'(exp_lru));
        chk("upd_wr_idx", 32'(wr_index), 32'(idx));
        chk("upd_mem_req", 32'(mem_req), 0);
        obs_upd_tag_we = tag_we;
        obs_upd_lru    = lru_wdata;
        stall++;
        m_tag[idx][vic]   = tag;
        m_val[idx][vic]   = 1;
        m_dirty[idx][vic] = 0;
        m_lru[idx]        = exp_lru;
        @(posedge clk); #1;
      end
    end
    if (!done) chk("rehit_done", 0, 1);
    pe_access_d = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    checks = 0; errors = 0;
    e_hit = 0; e_miss = 0; e_wb = 0;
    for (int s = 0; s < 256; s++) begin
      m_lru[s] = 3'b000;
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = '0; m_val[s][w] = 0; m_dirty[s][w] = 0;
      end
    end
    reset_n = 1'b0;
    pe_access_d = 1'b0; pe_write_d = 1'b0; pe_tag_d = '0; pe_index_d = '0;
    mem_ack = 1'b0;
    scramble();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_cnt();
    chk_zero("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset held for two cycles while a clean miss sits in FILL.
    pe_access_d = 1'b1; pe_write_d = 1'b1; pe_tag_d = 14'h0AA; pe_index_d = 8'h33;
    drive_compare(14'h0AA, 8'h33);
    @(negedge clk);
    chk("rmiss_stall", 32'(pe_stall), 1);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    chk("rfill_req", 32'(mem_req), 1);
    chk("rfill_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("rst_fill1");
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk_zero("rst_fill2");
    chk_cnt();
    @(posedge clk); #1;
    reset_n = 1'b1;
    pe_access_d = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    chk_cnt();
    chk_zero("post_rst");
    @(posedge clk); #1;

    // Dirty miss: way1 holds dirty tag 0x3FF and is the PLRU victim.
    m_tag[8'h10][0] = 14'h001; m_tag[8'h10][1] = 14'h3FF;
    m_tag[8'h10][2] = 14'h2AB; m_tag[8'h10][3] = 14'h3C0;
    for (int w = 0; w < 4; w++) m_val[8'h10][w] = 1;
    m_dirty[8'h10][1] = 1;
    m_lru[8'h10] = 3'b100;
    do_access(1'b0, 14'h155, 8'h10, 0, st);
    chk("dir_wb_addr", 32'(obs_wb_addr), 32'({14'h3FF, 8'h10}));
    chk("dir_wb_cnt", 32'(wb_cnt), 1);
    chk("dir_miss_cnt", 32'(miss_cnt), 1);

    // Clean miss into way3 with the fill acked in its second cycle.
    m_tag[8'h05][0] = 14'h001; m_tag[8'h05][1] = 14'h002;
    m_tag[8'h05][2] = 14'h003; m_tag[8'h05][3] = 14'h004;
    for (int w = 0; w < 4; w++) m_val[8'h05][w] = 1;
    m_lru[8'h05] = 3'b000;
    do_access(1'b0, 14'h1A2, 8'h05, 2, st);
    chk("dir_fill_addr", 32'(obs_fill_addr), 32'h1A205);
    chk("dir_upd_tag_we", 32'(obs_upd_tag_we), 32'h8);
    chk("dir_upd_lru_hi", 32'(obs_upd_lru[2:1]), 32'h3);
    chk("dir_clean_stall", 32'(st), 4);

    // Load hit on way2 and store hit on way0.
    m_tag[8'h33][2] = 14'h2AB; m_val[8'h33][2] = 1; m_lru[8'h33] = 3'b101;
    do_access(1'b0, 14'h2AB, 8'h33, 0, st);
    chk("dir_ld_lru", 32'(obs_lru), 32'h5);
    chk("dir_ld_mod_we", 32'(obs_mod_we), 0);
    chk("dir_ld_stall", 32'(st), 0);
    m_tag[8'hFF][0] = 14'h3C0; m_val[8'hFF][0] = 1; m_lru[8'hFF] = 3'b111;
    do_access(1'b1, 14'h3C0, 8'hFF, 0, st);
    chk("dir_st_lru", 32'(obs_lru), 32'h2);
    chk("dir_st_mod_we", 32'(obs_mod_we), 32'h1);

    // Random traffic over a few sets and a small tag pool.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom));
      else do_access(1'($urandom), tag_pool[$urandom_range(0, 5)],
                     idx_pool[$urandom_range(0, 3)], 0, st);
    end

    // Drive the hit counter into saturation, then stray acks in IDLE.
    for (int i = 0; i < MAXC + 5; i++) do_access(1'b0, 14'h1A2, 8'h05, 0, st);
    chk("hit_sat", 32'(hit_cnt), 32'(MAXC));
    for (int i = 0; i < 4; i++) idle_cycle(1'b1);
    do_access(1'b1, 14'h1A2, 8'h05, 0, st);
    chk("hit_sat_hold", 32'(hit_cnt), 32'(MAXC));
    idle_cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
